// File: rtl/top_sched.sv
// Two-port round-robin scheduler sharing one combinational datapath.
// Latches the granted operands, waits SETTLE cycles, returns the result with a one-cycle ack.
module top_sched #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             ack0,
  output logic [WIDTH-1:0] res0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack1,
  output logic [WIDTH-1:0] res1,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  input  logic [WIDTH-1:0] dp_res,
  output logic             busy,
  output logic             gnt_id
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] SETTLE_V = 4'(SETTLE);

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [WIDTH-1:0] dp_a_nxt, dp_b_nxt, res0_nxt, res1_nxt;
  logic             ack0_nxt, ack1_nxt, gnt_nxt, sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      dp_a   <= '0;
      dp_b   <= '0;
      res0   <= '0;
      res1   <= '0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      gnt_id <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dp_a   <= dp_a_nxt;
      dp_b   <= dp_b_nxt;
      res0   <= res0_nxt;
      res1   <= res1_nxt;
      ack0   <= ack0_nxt;
      ack1   <= ack1_nxt;
      gnt_id <= gnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dp_a_nxt  = dp_a;
    dp_b_nxt  = dp_b;
    res0_nxt  = res0;
    res1_nxt  = res1;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    gnt_nxt   = gnt_id;
    sel       = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // Under contention the port that did not win last time is served.
          sel       = (req0 && req1) ? ~gnt_id : req1;
          gnt_nxt   = sel;
          dp_a_nxt  = sel ? a1 : a0;
          dp_b_nxt  = sel ? b1 : b0;
          cnt_nxt   = SETTLE_V;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          if (gnt_id) begin
            res1_nxt = dp_res;
            ack1_nxt = 1'b1;
          end else begin
            res0_nxt = dp_res;
            ack0_nxt = 1'b1;
          end
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_top_sched.sv
// Bench for top_sched: two instances (SETTLE=1 and SETTLE=3) on shared stimulus,
// checked against a transaction-level timestamp model plus directed scenario checks.
module tb_top_sched;

  logic       clk, rst_n;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       ack0_o[2], ack1_o[2], busy_o[2], gnt_o[2];
  logic [3:0] res0_o[2], res1_o[2], dpa_o[2], dpb_o[2], dpres_i[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign dpres_i[g] = dpa_o[g] ^ dpb_o[g];
    top_sched #(.WIDTH(4), .SETTLE(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0), .b0(b0), .ack0(ack0_o[g]), .res0(res0_o[g]),
      .req1(req1), .a1(a1), .b1(b1), .ack1(ack1_o[g]), .res1(res1_o[g]),
      .dp_a(dpa_o[g]), .dp_b(dpb_o[g]), .dp_res(dpres_i[g]),
      .busy(busy_o[g]), .gnt_id(gnt_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: each grant fixes its ack edge and the next free edge.
  int         st[2] = '{1, 3};
  int         ed = 0;
  int         m_free[2], m_t0[2], m_ack[2];
  logic       m_gnt[2];
  logic [3:0] m_dpa[2], m_dpb[2], m_res0[2], m_res1[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_free[k] = 0; m_t0[k] = -1; m_ack[k] = -1; m_gnt[k] = 1'b1;
      m_dpa[k] = '0; m_dpb[k] = '0; m_res0[k] = '0; m_res1[k] = '0;
    end
  endtask

  task automatic check_outputs(input int k, input int e);
    logic is_ack;
    is_ack = (e == m_ack[k]);
    chk($sformatf("i%0d_dp_a", k), 8'(dpa_o[k]), 8'(m_dpa[k]));
    chk($sformatf("i%0d_dp_b", k), 8'(dpb_o[k]), 8'(m_dpb[k]));
    chk($sformatf("i%0d_res0", k), 8'(res0_o[k]), 8'(m_res0[k]));
    chk($sformatf("i%0d_res1", k), 8'(res1_o[k]), 8'(m_res1[k]));
    chk($sformatf("i%0d_ack0", k), 8'(ack0_o[k]), 8'(is_ack && !m_gnt[k]));
    chk($sformatf("i%0d_ack1", k), 8'(ack1_o[k]), 8'(is_ack && m_gnt[k]));
    chk($sformatf("i%0d_busy", k), 8'(busy_o[k]), 8'(e >= m_t0[k] && e <= m_ack[k]));
    chk($sformatf("i%0d_gnt", k), 8'(gnt_o[k]), 8'(m_gnt[k]));
  endtask

  task automatic step();
    logic       r0, r1, p;
    logic [3:0] xa0, xb0, xa1, xb1;
    r0 = req0; r1 = req1; xa0 = a0; xb0 = b0; xa1 = a1; xb1 = b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      if (ed >= m_free[k] && (r0 || r1)) begin
        p         = (r0 && r1) ? !m_gnt[k] : r1;
        m_gnt[k]  = p;
        m_dpa[k]  = p ? xa1 : xa0;
        m_dpb[k]  = p ? xb1 : xb0;
        m_t0[k]   = ed;
        m_ack[k]  = ed + st[k];
        m_free[k] = ed + st[k] + 2;
      end
      if (ed == m_ack[k]) begin
        if (m_gnt[k]) m_res1[k] = m_dpa[k] ^ m_dpb[k];
        else          m_res0[k] = m_dpa[k] ^ m_dpb[k];
      end
      check_outputs(k, ed);
    end
    ed++;
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    req0 = 1'($urandom); req1 = 1'($urandom);
    a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
  endtask

  // Called away from the rising edge; asserts reset at once and releases it on a falling edge.
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) check_outputs(k, -5);
    for (int c = 0; c < cycles; c++) begin
      rand_inputs();
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) check_outputs(k, -5);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    req0 = 1'b0; req1 = 1'b0;
    repeat (n) step();
  endtask

  int ack_e[$];
  int ack_p[$];

  initial begin
    rst_n = 1'b1;
    req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    model_reset();
    #2;
    // Reset with random inputs
    do_reset(3);

    // Single port 0 transaction
    idle(1);
    req0 = 1'b1; a0 = 4'b1010; b0 = 4'b1111;
    step();
    chk("t2_dp_a", 8'(dpa_o[0]), 8'h0a);
    chk("t2_dp_b", 8'(dpb_o[0]), 8'h0f);
    req0 = 1'b0;
    step();
    chk("t2_ack0", 8'(ack0_o[0]), 8'h01);
    chk("t2_res0", 8'(res0_o[0]), 8'h05);
    chk("t2_res1", 8'(res1_o[0]), 8'h00);
    idle(6);

    // Contention with both requests held, from fresh reset state
    do_reset(1);
    req0 = 1'b1; a0 = 4'b0101; b0 = 4'b1111;
    req1 = 1'b1; a1 = 4'b1111; b1 = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ack0_o[0]) begin ack_e.push_back(i); ack_p.push_back(0); end
      if (ack1_o[0]) begin ack_e.push_back(i); ack_p.push_back(1); end
    end
    chk("t3_nacks", 8'(ack_e.size()), 8'd3);
    if (ack_e.size() == 3) begin
      chk("t3_p0", 8'(ack_p[0]), 8'd0);
      chk("t3_p1", 8'(ack_p[1]), 8'd1);
      chk("t3_p2", 8'(ack_p[2]), 8'd0);
      chk("t3_gap1", 8'(ack_e[1] - ack_e[0]), 8'd3);
      chk("t3_gap2", 8'(ack_e[2] - ack_e[1]), 8'd3);
    end
    chk("t3_res0", 8'(res0_o[0]), 8'h0a);
    chk("t3_res1", 8'(res1_o[0]), 8'h00);
    idle(6);

    // Operand change during WAIT on the SETTLE=3 instance
    req0 = 1'b1; a0 = 4'b0011; b0 = 4'b0101;
    step();
    a0 = 4'b1100;
    step();
    chk("t4_noack_e1", 8'(ack0_o[1]), 8'h00);
    step();
    chk("t4_noack_e2", 8'(ack0_o[1]), 8'h00);
    step();
    chk("t4_ack_e3", 8'(ack0_o[1]), 8'h01);
    chk("t4_res0", 8'(res0_o[1]), 8'h06);
    req0 = 1'b0;
    idle(6);

    // Reset in the middle of a SETTLE=3 transaction
    req0 = 1'b1; a0 = 4'($urandom_range(1, 15)); b0 = 4'($urandom);
    step();
    step();
    do_reset(2);
    chk("t5_ack0", 8'(ack0_o[1]), 8'h00);
    chk("t5_dp_a", 8'(dpa_o[1]), 8'h00);
    chk("t5_res0", 8'(res0_o[1]), 8'h00);
    req0 = 1'b0; req1 = 1'b1; a1 = 4'b0110; b1 = 4'b0011;
    step();
    chk("t5_gnt", 8'(gnt_o[1]), 8'h01);
    chk("t5_busy", 8'(busy_o[1]), 8'h01);
    chk("t5_dp_a1", 8'(dpa_o[1]), 8'h06);
    req1 = 1'b0;
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
